rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 18 +
 rtl/rom_arb_pick.sv | 21 ++
 rtl/rom_arbiter.sv | 151 +++++++++++++++
 tb/tb_rom_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the two-port synchronous-ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum and the default address/data widths.
package rom_arb_pkg;

    localparam int ROM_ARB_ADDR_WIDTH = 8;
    localparam int ROM_ARB_DATA_WIDTH = 8;

    // IDLE: accepting requests; WAIT: ROM samples ROM_ADDR;
    // RESP: ROM_DATA is valid and is captured into the owner's RDATA.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rom_arb_state_e;

endpackage

// File: rtl/rom_arb_pick.sv
// Two-way winner selection for the ROM arbiter.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
// Ports: req0_i/req1_i requests, last_i = port granted last (1 = port 1),
//        gnt_o one-hot winner (bit 0 = port 0, bit 1 = port 1, 0 if no request).
module rom_arb_pick (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // Under contention the port that was not granted last wins. Tying
    // last_i high turns this into fixed priority for port 0.
    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = req0_i & (~req1_i | last_i);
        gnt_o[1] = req1_i & (~req0_i | ~last_i);
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port read arbiter in front of a single synchronous ROM.
// Latency: GNT one cycle and VALID three cycles after REQ is sampled in IDLE.
// Backpressure: at most one access in flight; requesters hold REQ until GNT.
// Ports: CLK/RESET (sync, active-high); per port REQx/ADDRx in, GNTx/VALIDx
//        pulses and RDATAx (held until the next VALIDx) out; ROM_ADDR out,
//        ROM_DATA in (valid one cycle after ROM_ADDR is sampled).
// Build option: define ROM_ARB_RR_EN for round-robin contention handling;
//        without it port 0 always wins contention.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ROM_ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ROM_ARB_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    output logic                  GNT0,
    output logic                  VALID0,
    output logic [DATA_WIDTH-1:0] RDATA0,
    input  logic                  REQ1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    output logic                  GNT1,
    output logic                  VALID1,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic [ADDR_WIDTH-1:0] ROM_ADDR,
    input  logic [DATA_WIDTH-1:0] ROM_DATA
);

    rom_arb_state_e        state_q, state_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  owner_q, owner_d;      // 1 = port 1 owns the access
    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    logic                  valid0_q, valid0_d;
    logic                  valid1_q, valid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic [1:0]            pick_gnt;
    logic                  pick_last;
    logic                  grant_now;

    rom_arb_pick u_pick (
        .req0_i (REQ0),
        .req1_i (REQ1),
        .last_i (pick_last),
        .gnt_o  (pick_gnt)
    );

    // A grant only happens from IDLE; REQ seen in WAIT/RESP is ignored.
    assign grant_now = (state_q == IDLE) && (pick_gnt != 2'b00);

`ifdef ROM_ARB_RR_EN
    // Last-granted pointer; reset to port 1 so port 0 wins first contention.
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (grant_now) begin
            last_d = pick_gnt[1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign pick_last = last_q;
`else
    assign pick_last = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        owner_d    = owner_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        valid0_d   = 1'b0;
        valid1_d   = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        case (state_q)
            IDLE: begin
                if (grant_now) begin
                    state_d    = WAIT;
                    owner_d    = pick_gnt[1];
                    rom_addr_d = pick_gnt[1] ? ADDR1 : ADDR0;
                    gnt0_d     = pick_gnt[0];
                    gnt1_d     = pick_gnt[1];
                end
            end
            WAIT: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (owner_q) begin
                    valid1_d = 1'b1;
                    rdata1_d = ROM_DATA;
                end else begin
                    valid0_d = 1'b1;
                    rdata0_d = ROM_DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            owner_q    <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            owner_q    <= owner_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            valid0_q   <= valid0_d;
            valid1_q   <= valid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign ROM_ADDR = rom_addr_q;
    assign GNT0     = gnt0_q;
    assign GNT1     = gnt1_q;
    assign VALID0   = valid0_q;
    assign VALID1   = valid1_q;
    assign RDATA0   = rdata0_q;
    assign RDATA1   = rdata1_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed and random bench for rom_arbiter with a synchronous ROM model.
// Latency: n/a (testbench).
// Backpressure: requesters hold REQ until GNT and drop it in the GNT cycle.
module tb_rom_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ0 = 1'b0;
    logic       REQ1 = 1'b0;
    logic [7:0] ADDR0 = 8'h00;
    logic [7:0] ADDR1 = 8'h00;
    logic [7:0] ROM_DATA = 8'h00;
    logic       GNT0, GNT1, VALID0, VALID1;
    logic [7:0] RDATA0, RDATA1, ROM_ADDR;

    logic [7:0] rom [256];

    int n_pass  = 0;
    int n_total = 0;

    rom_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ0     (REQ0),
        .ADDR0    (ADDR0),
        .GNT0     (GNT0),
        .VALID0   (VALID0),
        .RDATA0   (RDATA0),
        .REQ1     (REQ1),
        .ADDR1    (ADDR1),
        .GNT1     (GNT1),
        .VALID1   (VALID1),
        .RDATA1   (RDATA1),
        .ROM_ADDR (ROM_ADDR),
        .ROM_DATA (ROM_DATA)
    );

    always #5 CLK = ~CLK;

    // Synchronous ROM: data appears one cycle after the address is sampled.
    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
        step(); step();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; REQ0 = 1'b1; ADDR0 = 8'h10;
        step(); step();
        n_total++;
        if ({GNT0, GNT1, VALID0, VALID1} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {GNT0, GNT1, VALID0, VALID1});
        else n_pass++;
        n_total++;
        if (ROM_ADDR !== 8'h00) $display("FAIL reset_rom_addr: got %h want 00", ROM_ADDR);
        else n_pass++;
        n_total++;
        if ({RDATA0, RDATA1} !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", {RDATA0, RDATA1});
        else n_pass++;
        REQ0 = 1'b0; RESET = 1'b0;
        step(); step();
        n_total++;
        if ({GNT0, GNT1, VALID0, VALID1, ROM_ADDR} !== 12'h000)
            $display("FAIL idle_hold: got %h want 000", {GNT0, GNT1, VALID0, VALID1, ROM_ADDR});
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        REQ0 = 1'b1; ADDR0 = 8'h10;
        step();
        n_total++;
        if ({GNT0, GNT1, VALID0, VALID1} !== 4'b1000)
            $display("FAIL single_gnt: got %b want 1000", {GNT0, GNT1, VALID0, VALID1});
        else n_pass++;
        n_total++;
        if (ROM_ADDR !== 8'h10) $display("FAIL single_rom_addr: got %h want 10", ROM_ADDR);
        else n_pass++;
        REQ0 = 1'b0;
        step();
        n_total++;
        if ({GNT0, GNT1, VALID0, VALID1} !== 4'b0000)
            $display("FAIL single_wait: got %b want 0000", {GNT0, GNT1, VALID0, VALID1});
        else n_pass++;
        step();
        n_total++;
        if ({GNT0, GNT1, VALID0, VALID1} !== 4'b0010)
            $display("FAIL single_valid: got %b want 0010", {GNT0, GNT1, VALID0, VALID1});
        else n_pass++;
        n_total++;
        if ({RDATA0, RDATA1} !== 16'hA500) $display("FAIL single_rdata: got %h want a500", {RDATA0, RDATA1});
        else n_pass++;
        step();
        n_total++;
        if ({VALID0, RDATA0} !== 9'h0A5) $display("FAIL single_hold: got %h want 0a5", {VALID0, RDATA0});
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [7:0] exp_r1;
        do_reset();
        REQ0 = 1'b1; ADDR0 = 8'h10;
        REQ1 = 1'b1; ADDR1 = 8'h20;
        for (int k = 0; k < 4; k++) begin
            int w;
            logic [3:0] exp_f;
            logic [7:0] got_d, exp_d;
`ifdef ROM_ARB_RR_EN
            w = k % 2;
`else
            w = 0;
`endif
            step();
            exp_f = (w == 0) ? 4'b1000 : 4'b0100;
            n_total++;
            if ({GNT0, GNT1, VALID0, VALID1} !== exp_f)
                $display("FAIL cont_gnt[%0d]: got %b want %b", k, {GNT0, GNT1, VALID0, VALID1}, exp_f);
            else n_pass++;
            if (w == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
            step(); step();
            exp_f = (w == 0) ? 4'b0010 : 4'b0001;
            got_d = (w == 0) ? RDATA0 : RDATA1;
            exp_d = (w == 0) ? 8'hA5 : 8'h3C;
            n_total++;
            if ({GNT0, GNT1, VALID0, VALID1} !== exp_f || got_d !== exp_d)
                $display("FAIL cont_valid[%0d]: got %b/%h want %b/%h", k,
                         {GNT0, GNT1, VALID0, VALID1}, got_d, exp_f, exp_d);
            else n_pass++;
            if (k < 3) begin
                if (w == 0) REQ0 = 1'b1; else REQ1 = 1'b1;
            end else begin
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
        end
`ifdef ROM_ARB_RR_EN
        exp_r1 = 8'h3C;
`else
        exp_r1 = 8'h00;
`endif
        step(); step();
        n_total++;
        if (RDATA1 !== exp_r1) $display("FAIL cont_port1: got %h want %h", RDATA1, exp_r1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic seen_valid;
        do_reset();
        REQ0 = 1'b1; ADDR0 = 8'h10;
        step();
        REQ0 = 1'b0;
        step(); step();
        REQ0 = 1'b1; ADDR0 = 8'h20;
        step();
        REQ0 = 1'b0; RESET = 1'b1;
        step();
        n_total++;
        if ({GNT0, GNT1, VALID0, VALID1, ROM_ADDR, RDATA0, RDATA1} !== 28'h0)
            $display("FAIL abort_outputs: got %h want 0000000",
                     {GNT0, GNT1, VALID0, VALID1, ROM_ADDR, RDATA0, RDATA1});
        else n_pass++;
        RESET = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            seen_valid = seen_valid | VALID0 | VALID1;
        end
        n_total++;
        if (seen_valid !== 1'b0) $display("FAIL abort_no_valid: got %b want 0", seen_valid);
        else n_pass++;
        REQ1 = 1'b1; ADDR1 = 8'h20;
        step();
        n_total++;
        if ({GNT0, GNT1} !== 2'b01) $display("FAIL post_abort_gnt: got %b want 01", {GNT0, GNT1});
        else n_pass++;
        REQ1 = 1'b0;
        step(); step();
        n_total++;
        if ({VALID1, RDATA1} !== 9'h13C) $display("FAIL post_abort_rdata: got %h want 13c", {VALID1, RDATA1});
        else n_pass++;
    endtask

    task automatic test_addr_change();
        do_reset();
        REQ0 = 1'b1; ADDR0 = 8'h10;
        step();
        REQ0 = 1'b0; ADDR0 = 8'h20;
        step();
        n_total++;
        if (ROM_ADDR !== 8'h10) $display("FAIL addr_hold: got %h want 10", ROM_ADDR);
        else n_pass++;
        step();
        n_total++;
        if ({VALID0, RDATA0} !== 9'h1A5) $display("FAIL addr_change_rdata: got %h want 1a5", {VALID0, RDATA0});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        logic [7:0] prev0, prev1, e;
        do_reset();
        prev0 = RDATA0; prev1 = RDATA1;
        for (int c = 0; c < 1020; c++) begin
            step();
            n_total++;
            if ((GNT0 && GNT1) || (VALID0 && VALID1) || (!VALID0 && RDATA0 !== prev0) ||
                (!VALID1 && RDATA1 !== prev1))
                $display("FAIL rand_exclusive[%0d]: got g=%b%b v=%b%b r=%h/%h want one-hot, held %h/%h",
                         c, GNT0, GNT1, VALID0, VALID1, RDATA0, RDATA1, prev0, prev1);
            else n_pass++;
            if (GNT0) begin q0.push_back(rom[ADDR0]); REQ0 = 1'b0; end
            if (GNT1) begin q1.push_back(rom[ADDR1]); REQ1 = 1'b0; end
            if (VALID0) begin
                n_total++;
                if (q0.size() == 0) $display("FAIL rand_valid0_spurious[%0d]: got VALID0 want none", c);
                else begin
                    e = q0.pop_front();
                    if (RDATA0 !== e) $display("FAIL rand_rdata0[%0d]: got %h want %h", c, RDATA0, e);
                    else n_pass++;
                end
            end
            if (VALID1) begin
                n_total++;
                if (q1.size() == 0) $display("FAIL rand_valid1_spurious[%0d]: got VALID1 want none", c);
                else begin
                    e = q1.pop_front();
                    if (RDATA1 !== e) $display("FAIL rand_rdata1[%0d]: got %h want %h", c, RDATA1, e);
                    else n_pass++;
                end
            end
            prev0 = RDATA0; prev1 = RDATA1;
            if (c < 1000) begin
                if (!REQ0 && !GNT0) begin
                    ADDR0 = 8'($urandom_range(0, 255));
                    REQ0  = ($urandom_range(0, 2) != 0);
                end
                if (!REQ1 && !GNT1) begin
                    ADDR1 = 8'($urandom_range(0, 255));
                    REQ1  = ($urandom_range(0, 2) != 0);
                end
            end
        end
        n_total++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL rand_drain: got %0d/%0d outstanding want 0/0", q0.size(), q1.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37 + 11) & 255);
        rom[8'h10] = 8'hA5;
        rom[8'h20] = 8'h3C;
        test_reset();
        test_single();
        test_contention();
        test_reset_mid();
        test_addr_change();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
